sc_frogpoint_register: RTL

- Position datapath directly downstream of the point state machine.
- Consumes its active-low strobes (clear, changeP, load0, load1) and 2-bit shift selection, and holds the frog position as a row index plus a one-hot column vector.
- Returns the bottom-edge flag and 2-bit side-edge code that the state machine uses to gate moves.
- Drives position, visibility and top-reached status to the display matrix and game-status logic.

---
 rtl/sc_frogpoint_register_pkg.sv | 29 ++
 rtl/sc_frogpoint_column_shifter.sv | 64 ++++++
 rtl/sc_frogpoint_register.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sc_frogpoint_register_pkg.sv
// Shared encodings and defaults for the frog position datapath.
// Consumed by sc_frogpoint_register and sc_frogpoint_column_shifter.
package sc_frogpoint_register_pkg;

  typedef enum logic [1:0] {
    SHIFT_IDLE  = 2'b00,
    SHIFT_LEFT  = 2'b01,
    SHIFT_RIGHT = 2'b10,
    SHIFT_HOLD  = 2'b11
  } shiftSel_e;

  typedef enum logic [1:0] {
    SIDE_NONE  = 2'b00,
    SIDE_RIGHT = 2'b01,
    SIDE_LEFT  = 2'b10,
    SIDE_BOTH  = 2'b11
  } sideCode_e;

  localparam int DEFAULT_COLUMNS      = 8;
  localparam int DEFAULT_ROWS         = 8;
  localparam int DEFAULT_START_COLUMN = 3;
  localparam int DEFAULT_START_ROW    = 0;

  // A single-row board still needs a one-bit row index.
  function automatic int rowWidth(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/sc_frogpoint_column_shifter.sv
// One-hot column register with edge-saturating shifts, side-edge decode
// and recovery to the start column if the vector ever stops being one-hot.
module sc_frogpoint_column_shifter
  import sc_frogpoint_register_pkg::*;
#(
  parameter int COLUMNS      = DEFAULT_COLUMNS,
  parameter int START_COLUMN = DEFAULT_START_COLUMN
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_restart,
  input  logic               i_shiftEnable,
  input  logic [1:0]         i_shiftSel,
  output logic [COLUMNS-1:0] o_column,
  output logic [1:0]         o_side
);

  localparam logic [COLUMNS-1:0] START_VEC = COLUMNS'(1) << START_COLUMN;

  logic [COLUMNS-1:0] r_column;
  logic [COLUMNS-1:0] w_columnNext;
  logic               w_oneHot;

  assign w_oneHot = $onehot(r_column);

  // Shifts saturate at the edges: a bit already at the MSB/LSB stays put.
  always_comb begin
    w_columnNext = r_column;
    if (i_restart || !w_oneHot) begin
      w_columnNext = START_VEC;
    end else if (i_shiftEnable) begin
      case (i_shiftSel)
        SHIFT_LEFT: begin
          if (!r_column[COLUMNS-1]) w_columnNext = r_column << 1;
        end
        SHIFT_RIGHT: begin
          if (!r_column[0]) w_columnNext = r_column >> 1;
        end
        default: w_columnNext = r_column;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_column <= START_VEC;
    end else begin
      r_column <= w_columnNext;
    end
  end

  assign o_column = r_column;

  generate
    if (COLUMNS == 1) begin : g_singleColumn
      assign o_side = SIDE_BOTH;
    end else begin : g_multiColumn
      assign o_side = r_column[COLUMNS-1] ? SIDE_LEFT  :
                      r_column[0]         ? SIDE_RIGHT :
                                            SIDE_NONE;
    end
  endgenerate

endmodule

// File: rtl/sc_frogpoint_register.sv
// Frog position datapath driven by the point state machine strobes.
// Optional hop counter enabled by defining FROGPOINT_HOPCOUNT_EN.
module sc_frogpoint_register
  import sc_frogpoint_register_pkg::*;
#(
  parameter  int COLUMNS      = DEFAULT_COLUMNS,
  parameter  int ROWS         = DEFAULT_ROWS,
  parameter  int START_COLUMN = DEFAULT_START_COLUMN,
  parameter  int START_ROW    = DEFAULT_START_ROW,
  localparam int ROW_W        = rowWidth(ROWS)
) (
  input  logic               SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic               SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic               clear_InLow,
  input  logic               changeP_InLow,
  input  logic               load0_InLow,
  input  logic               load1_InLow,
  input  logic [1:0]         shiftselection_InBus,
  output logic [COLUMNS-1:0] column_OutBus,
  output logic [ROW_W-1:0]   row_OutBus,
  output logic               bottomsidecomparator_OutLow,
  output logic [1:0]         sidecomparator_OutBus,
  output logic               visible_OutHigh,
  output logic               topreached_OutHigh,
  output logic [7:0]         hopcount_OutBus
);

  localparam logic [ROW_W-1:0] START_ROW_V = ROW_W'(START_ROW);
  localparam logic [ROW_W-1:0] TOP_ROW     = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] PRE_TOP_ROW = ROW_W'(ROWS - 2);

  logic [ROW_W-1:0]   r_row;
  logic               r_visible;
  logic               r_topReached;
  logic [COLUMNS-1:0] w_column;

  logic w_clear;
  logic w_freeze;
  logic w_up;
  logic w_down;
  logic w_shiftEn;
  logic w_rowUp;
  logic w_rowDown;

  // Strict priority: each strobe only acts when every higher one is idle.
  assign w_clear   = !clear_InLow;
  assign w_freeze  = clear_InLow && !changeP_InLow;
  assign w_up      = clear_InLow && changeP_InLow && !load0_InLow;
  assign w_down    = clear_InLow && changeP_InLow && load0_InLow && !load1_InLow;
  assign w_shiftEn = clear_InLow && changeP_InLow && load0_InLow && load1_InLow;

  assign w_rowUp   = w_up   && (r_row < TOP_ROW);
  assign w_rowDown = w_down && (r_row != '0);

  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      r_row <= START_ROW_V;
    end else if (w_clear) begin
      r_row <= START_ROW_V;
    end else if (w_rowUp) begin
      r_row <= r_row + ROW_W'(1);
    end else if (w_rowDown) begin
      r_row <= r_row - ROW_W'(1);
    end
  end

  // Only the step into the top row fires the pulse; clear and freeze can never fire it.
  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      r_topReached <= 1'b0;
      r_visible    <= 1'b0;
    end else begin
      r_topReached <= w_rowUp && (r_row == PRE_TOP_ROW);
      r_visible    <= changeP_InLow;
    end
  end

  sc_frogpoint_column_shifter #(
    .COLUMNS      (COLUMNS),
    .START_COLUMN (START_COLUMN)
  ) u_columnShifter (
    .i_clock       (SC_STATEMACHINEPOINT_CLOCK_50),
    .i_reset       (SC_STATEMACHINEPOINT_RESET_InHigh),
    .i_restart     (w_clear),
    .i_shiftEnable (w_shiftEn),
    .i_shiftSel    (shiftselection_InBus),
    .o_column      (w_column),
    .o_side        (sidecomparator_OutBus)
  );

`ifdef FROGPOINT_HOPCOUNT_EN
  logic       w_colMove;
  logic       w_move;
  logic [7:0] r_hopCount;

  // A one-hot recovery is not a hop, so the column only counts from a valid vector.
  assign w_colMove = w_shiftEn && $onehot(w_column) &&
                     (((shiftselection_InBus == SHIFT_LEFT)  && !w_column[COLUMNS-1]) ||
                      ((shiftselection_InBus == SHIFT_RIGHT) && !w_column[0]));
  assign w_move    = w_rowUp || w_rowDown || w_colMove;

  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      r_hopCount <= 8'd0;
    end else if (w_clear) begin
      r_hopCount <= 8'd0;
    end else if (w_move) begin
      r_hopCount <= r_hopCount + 8'd1;
    end
  end

  assign hopcount_OutBus = r_hopCount;
`else
  assign hopcount_OutBus = 8'd0;
`endif

  assign column_OutBus               = w_column;
  assign row_OutBus                  = r_row;
  assign bottomsidecomparator_OutLow = (r_row != '0);
  assign visible_OutHigh             = r_visible;
  assign topreached_OutHigh          = r_topReached;

endmodule
